// File: rtl/anim_sprite_pkg.sv
// Shared constants and helpers for the animated sprite renderer.
package anim_sprite_pkg;
  localparam int RGB_W    = 24;
  localparam int HCOORD_W = 11;
  localparam int VCOORD_W = 10;
  localparam logic [7:0] TRANSP_IDX_DEF = 8'h00;

  // One bit wider than the screen coordinates so box edges never wrap.
  typedef logic [HCOORD_W:0] hsum_t;
  typedef logic [VCOORD_W:0] vsum_t;

  // Contents used when no init file is given. The low byte serves as the
  // index pattern and the full word as the palette pattern.
  function automatic logic [RGB_W-1:0] rom_default(input logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {a ^ 8'hA5, ~a, a + 8'h11};
  endfunction
endpackage

// File: rtl/anim_sprite_rom.sv
// Synchronous-read ROM, loaded from a built-in pattern.
module anim_sprite_rom
  import anim_sprite_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int DATA_W    = 8,
  parameter     INIT_FILE = "",
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] data_d, data_q;

  always_comb data_d = DATA_W'(rom_default(32'(addr)));

  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;
endmodule

// File: rtl/anim_sprite.sv
// Animated sprite: box test + address register, index ROM, palette ROM
// (3-deep pixel path) and a frame_tick-driven frame sequencer.
module anim_sprite
  import anim_sprite_pkg::*;
#(
  parameter int         WIDTH      = 30,
  parameter int         HEIGHT     = 45,
  parameter int         FRAMES     = 4,
  parameter int         SCALE_LOG2 = 0,
  parameter int         FRAME_DIV  = 8,
  parameter logic [7:0] TRANSP_IDX = TRANSP_IDX_DEF,
  parameter             IDX_FILE   = "",
  parameter             PAL_FILE   = "",
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                pixel_clk,
  input  logic                reset,
  input  logic [HCOORD_W-1:0] x,
  input  logic [HCOORD_W-1:0] hcount,
  input  logic [VCOORD_W-1:0] y,
  input  logic [VCOORD_W-1:0] vcount,
  input  logic                frame_tick,
  input  logic                anim_en,
  input  logic                loop,
  input  logic                restart,
  output logic [RGB_W-1:0]    pixel,
  output logic                opaque,
  output logic [FW-1:0]       frame,
  output logic                done
);
  localparam int DEPTH = WIDTH * HEIGHT * FRAMES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(FRAME_DIV - 1);
  localparam logic [FW-1:0] LAST    = FW'(FRAMES - 1);

  logic [FW-1:0] frame_d, frame_q;
  logic [DW-1:0] div_d, div_q;
  logic          done_d, done_q;
  logic          step;

  hsum_t               h_end;
  vsum_t               v_end;
  logic                in_box;
  logic [HCOORD_W-1:0] dx;
  logic [VCOORD_W-1:0] dy;
  logic [AW-1:0]       addr_d, addr_q;
  logic [2:0]          box_d, box_q;
  logic                transp_d, transp_q;
  logic [7:0]          idx;
  logic [RGB_W-1:0]    pal;

  // Frame sequencer; restart overrides any step in the same cycle.
  always_comb begin
    div_d   = div_q;
    step    = 1'b0;
    frame_d = frame_q;
    done_d  = done_q && !loop;
    if (anim_en && frame_tick) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        step  = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    if (step) begin
      if (frame_q != LAST) frame_d = frame_q + FW'(1);
      else if (loop)       frame_d = '0;
      if (!loop && frame_d == LAST) done_d = 1'b1;
    end
    if (restart) begin
      frame_d = '0;
      div_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    h_end  = hsum_t'(x) + hsum_t'(WIDTH << SCALE_LOG2);
    v_end  = vsum_t'(y) + vsum_t'(HEIGHT << SCALE_LOG2);
    in_box = (hcount >= x) && (hsum_t'(hcount) < h_end) &&
             (vcount >= y) && (vsum_t'(vcount) < v_end);
    dx     = (hcount - x) >> SCALE_LOG2;
    dy     = (vcount - y) >> SCALE_LOG2;
    addr_d = in_box ? AW'(32'(frame_q) * 32'(WIDTH * HEIGHT) +
                          32'(dy) * 32'(WIDTH) + 32'(dx)) : '0;
    box_d    = {box_q[1:0], in_box};
    transp_d = (idx == TRANSP_IDX);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      frame_q  <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      box_q    <= '0;
      transp_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      div_q    <= div_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      box_q    <= box_d;
      transp_q <= transp_d;
    end
  end

  anim_sprite_rom #(.DEPTH(DEPTH), .DATA_W(8), .INIT_FILE(IDX_FILE)) u_idx_rom (
    .clk(pixel_clk), .addr(addr_q), .data(idx)
  );

  anim_sprite_rom #(.DEPTH(256), .DATA_W(RGB_W), .INIT_FILE(PAL_FILE)) u_pal_rom (
    .clk(pixel_clk), .addr(idx), .data(pal)
  );

  // ROM data is never reset; the in-box pipeline masks it instead.
  assign opaque = box_q[2] && !transp_q;
  assign pixel  = opaque ? pal : '0;
  assign frame  = frame_q;
  assign done   = done_q;
endmodule

// File: tb/tb_anim_sprite.sv
// Randomized and directed bench for anim_sprite: two configurations share stimulus.
module tb_anim_sprite;
  logic        clk, rst;
  logic [10:0] x, hcount;
  logic [9:0]  y, vcount;
  logic        frame_tick, anim_en, loop, restart;
  logic [23:0] pix_a, pix_b;
  logic        opq_a, opq_b, done_a, done_b;
  logic [1:0]  frm_a, frm_b;

  int n_chk = 0;
  int n_fail = 0;

  // Per-configuration parameters: [0] small box, [1] default size scaled x2
  int P_W[2]   = '{4, 30};
  int P_H[2]   = '{2, 45};
  int P_S[2]   = '{0, 1};
  int P_DIV[2] = '{2, 1};
  int P_TR[2]  = '{24, 0};
  localparam int FR = 4;

  int          m_frame[2];
  int          m_div[2];
  bit          m_done[2];
  logic [24:0] m_pipe[2][3];

  anim_sprite #(.WIDTH(4), .HEIGHT(2), .FRAMES(4), .SCALE_LOG2(0), .FRAME_DIV(2),
                .TRANSP_IDX(8'h18)) u_dut_a (
    .pixel_clk(clk), .reset(rst), .x(x), .hcount(hcount), .y(y), .vcount(vcount),
    .frame_tick(frame_tick), .anim_en(anim_en), .loop(loop), .restart(restart),
    .pixel(pix_a), .opaque(opq_a), .frame(frm_a), .done(done_a));

  anim_sprite #(.WIDTH(30), .HEIGHT(45), .FRAMES(4), .SCALE_LOG2(1), .FRAME_DIV(1),
                .TRANSP_IDX(8'h00)) u_dut_b (
    .pixel_clk(clk), .reset(rst), .x(x), .hcount(hcount), .y(y), .vcount(vcount),
    .frame_tick(frame_tick), .anim_en(anim_en), .loop(loop), .restart(restart),
    .pixel(pix_b), .opaque(opq_b), .frame(frm_b), .done(done_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Colour of texel at linear address a under the built-in ROM contents
  function automatic logic [23:0] texel(int a);
    int i;
    i = (a + 17) % 256;
    return {8'(i ^ 165), 8'(255 - i), 8'((i + 17) % 256)};
  endfunction

  function automatic logic [24:0] model_pix(int k, int hc, int vc, int xx, int yy, int fr);
    int a;
    if (hc < xx || hc >= xx + (P_W[k] << P_S[k]) ||
        vc < yy || vc >= yy + (P_H[k] << P_S[k])) return '0;
    a = fr * P_W[k] * P_H[k] + ((vc - yy) >> P_S[k]) * P_W[k] + ((hc - xx) >> P_S[k]);
    if ((a + 17) % 256 == P_TR[k]) return '0;
    return {1'b1, texel(a)};
  endfunction

  // Advance model and DUT by one edge; outputs are sampled 1 ns after it.
  task automatic cycle();
    logic [24:0] fresh;
    bit stepped;
    for (int k = 0; k < 2; k++) begin
      fresh = model_pix(k, int'(hcount), int'(vcount), int'(x), int'(y), m_frame[k]);
      if (rst) begin
        m_pipe[k][0] = '0; m_pipe[k][1] = '0; m_pipe[k][2] = '0;
        m_frame[k] = 0; m_div[k] = 0; m_done[k] = 0;
      end else begin
        m_pipe[k][2] = m_pipe[k][1];
        m_pipe[k][1] = m_pipe[k][0];
        m_pipe[k][0] = fresh;
        if (restart) begin
          m_frame[k] = 0; m_div[k] = 0; m_done[k] = 0;
        end else begin
          stepped = 0;
          if (anim_en && frame_tick) begin
            m_div[k]++;
            if (m_div[k] == P_DIV[k]) begin m_div[k] = 0; stepped = 1; end
          end
          if (loop) m_done[k] = 0;
          if (stepped) begin
            if (m_frame[k] < FR - 1) m_frame[k]++;
            else if (loop) m_frame[k] = 0;
            if (!loop && m_frame[k] == FR - 1) m_done[k] = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0; cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 11'd100; y = 10'd50; hcount = 11'd101; vcount = 10'd50;
    frame_tick = 1'b1; anim_en = 1'b1; loop = 1'b1; restart = 1'b0;
    cycle(); cycle();
    n_chk++;
    if ({pix_a, opq_a, frm_a, done_a} !== 28'd0) begin
      n_fail++; $display("FAIL reset_a: got %h/%b/%0d/%b want 0", pix_a, opq_a, frm_a, done_a);
    end
    n_chk++;
    if ({pix_b, opq_b, frm_b, done_b} !== 28'd0) begin
      n_fail++; $display("FAIL reset_b: got %h/%b/%0d/%b want 0", pix_b, opq_b, frm_b, done_b);
    end
    rst = 1'b0; frame_tick = 1'b0; anim_en = 1'b0;
    cycle();
  endtask

  task automatic test_row();
    logic exp_opq[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    x = 11'd100; y = 10'd50; vcount = 10'd50;
    for (int j = 0; j < 9; j++) begin
      hcount = (j < 6) ? 11'(99 + j) : 11'd0;
      cycle();
      if (j >= 2) begin
        n_chk++;
        if (opq_a !== exp_opq[j-2] || pix_a !== (exp_opq[j-2] ? texel(j - 3) : 24'd0)) begin
          n_fail++;
          $display("FAIL row_h%0d: got %b/%h want %b/%h", 97 + j, opq_a, pix_a,
                   exp_opq[j-2], exp_opq[j-2] ? texel(j - 3) : 24'd0);
        end
      end
    end
  endtask

  task automatic test_scale();
    int hs[3] = '{100, 101, 102};
    int vs[3] = '{50, 51, 51};
    int as[3] = '{0, 0, 1};
    x = 11'd100; y = 10'd50;
    for (int j = 0; j < 5; j++) begin
      hcount = (j < 3) ? 11'(hs[j]) : 11'd0;
      vcount = (j < 3) ? 10'(vs[j]) : 10'd0;
      cycle();
      if (j >= 2) begin
        n_chk++;
        if (opq_b !== 1'b1 || pix_b !== texel(as[j-2])) begin
          n_fail++;
          $display("FAIL scale_h%0d_v%0d: got %b/%h want 1/%h", hs[j-2], vs[j-2],
                   opq_b, pix_b, texel(as[j-2]));
        end
      end
    end
  endtask

  task automatic test_transp_edge();
    // Row 1, column 3 of frame 0 holds the transparent index in config A
    x = 11'd100; y = 10'd50; vcount = 10'd51; hcount = 11'd103;
    cycle(); hcount = 11'd102; cycle(); hcount = 11'd0; cycle();
    n_chk++;
    if (opq_a !== 1'b0 || pix_a !== 24'd0) begin
      n_fail++; $display("FAIL transp: got %b/%h want 0/0", opq_a, pix_a);
    end
    cycle();
    n_chk++;
    if (opq_a !== 1'b1 || pix_a !== texel(6)) begin
      n_fail++; $display("FAIL transp_nbr: got %b/%h want 1/%h", opq_a, pix_a, texel(6));
    end
    x = 11'd2040; y = 10'd50; vcount = 10'd60;
    for (int j = 0; j < 12; j++) begin
      hcount = (j < 10) ? 11'(j) : 11'd0;
      cycle();
      if (j >= 2) begin
        n_chk++;
        if (opq_a !== 1'b0 || opq_b !== 1'b0) begin
          n_fail++; $display("FAIL edge_wrap_h%0d: got %b/%b want 0/0", j - 2, opq_a, opq_b);
        end
      end
    end
  endtask

  task automatic test_loop();
    int seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    anim_en = 1'b1; loop = 1'b1;
    restart = 1'b1; cycle(); restart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (int'(frm_a) !== seq[i] || done_a !== 1'b0 || int'(frm_b) !== m_frame[1]) begin
        n_fail++;
        $display("FAIL loop_t%0d: got a=%0d/%b b=%0d want a=%0d/0 b=%0d", i, frm_a, done_a,
                 frm_b, seq[i], m_frame[1]);
      end
      tick_once();
    end
  endtask

  task automatic test_oneshot();
    loop = 1'b0; anim_en = 1'b1;
    restart = 1'b1; cycle(); restart = 1'b0;
    for (int i = 0; i < 8; i++) tick_once();
    n_chk++;
    if (frm_b !== 2'd3 || done_b !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_hold: got %0d/%b want 3/1", frm_b, done_b);
    end
    restart = 1'b1; cycle(); restart = 1'b0;
    n_chk++;
    if (frm_b !== 2'd0 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_restart: got %0d/%b want 0/0", frm_b, done_b);
    end
    tick_once(); tick_once();
    restart = 1'b1; frame_tick = 1'b1; cycle(); restart = 1'b0; frame_tick = 1'b0;
    n_chk++;
    if (frm_b !== 2'd0 || frm_a !== 2'd0) begin
      n_fail++; $display("FAIL restart_vs_tick: got %0d/%0d want 0/0", frm_b, frm_a);
    end
    for (int i = 0; i < 4; i++) tick_once();
    loop = 1'b1; cycle();
    n_chk++;
    if (done_b !== 1'b0) begin
      n_fail++; $display("FAIL loop_clears_done: got %b want 0", done_b);
    end
    tick_once();
    n_chk++;
    if (frm_b !== 2'd0) begin
      n_fail++; $display("FAIL loop_resume: got %0d want 0", frm_b);
    end
  endtask

  task automatic test_reset_mid();
    anim_en = 1'b1; loop = 1'b1;
    restart = 1'b1; cycle(); restart = 1'b0;
    for (int i = 0; i < 4; i++) tick_once();
    anim_en = 1'b0;
    x = 11'd100; y = 10'd50; vcount = 10'd50; hcount = 11'd100;
    cycle(); cycle(); cycle();
    n_chk++;
    if (frm_a !== 2'd2 || opq_a !== 1'b1 || pix_a !== texel(16)) begin
      n_fail++; $display("FAIL mid_pre: got %0d/%b/%h want 2/1/%h", frm_a, opq_a, pix_a, texel(16));
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    n_chk++;
    if (frm_a !== 2'd0 || opq_a !== 1'b0 || pix_a !== 24'd0) begin
      n_fail++; $display("FAIL mid_reset: got %0d/%b/%h want 0/0/0", frm_a, opq_a, pix_a);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_chk++;
      if (opq_a !== (i == 2) || pix_a !== ((i == 2) ? texel(0) : 24'd0)) begin
        n_fail++; $display("FAIL mid_refill%0d: got %b/%h", i, opq_a, pix_a);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (n % 16 == 0) begin
        x = 11'($urandom_range(0, 2047));
        y = 10'($urandom_range(0, 1023));
      end
      hcount = 11'(int'(x) + int'($urandom_range(0, 130)) - 5);
      vcount = 10'(int'(y) + int'($urandom_range(0, 100)) - 5);
      frame_tick = ($urandom_range(0, 3) == 0);
      anim_en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) loop = ~loop;
      restart    = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 59) == 0);
      cycle();
      n_chk++;
      if ({pix_a, opq_a, int'(frm_a), done_a} !==
          {m_pipe[0][2][23:0], m_pipe[0][2][24], m_frame[0], m_done[0]}) begin
        n_fail++;
        $display("FAIL rand_a@%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", n, pix_a, opq_a, frm_a,
                 done_a, m_pipe[0][2][23:0], m_pipe[0][2][24], m_frame[0], m_done[0]);
      end
      n_chk++;
      if ({pix_b, opq_b, int'(frm_b), done_b} !==
          {m_pipe[1][2][23:0], m_pipe[1][2][24], m_frame[1], m_done[1]}) begin
        n_fail++;
        $display("FAIL rand_b@%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", n, pix_b, opq_b, frm_b,
                 done_b, m_pipe[1][2][23:0], m_pipe[1][2][24], m_frame[1], m_done[1]);
      end
    end
    rst = 1'b0; restart = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_frame[k] = 0; m_div[k] = 0; m_done[k] = 0;
      for (int s = 0; s < 3; s++) m_pipe[k][s] = '0;
    end
    test_reset();
    test_row();
    test_scale();
    test_transp_edge();
    test_loop();
    test_oneshot();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/anim_sprite.md
ANIM_SPRITE -- requirements
Module: anim_sprite

Interface
REQ-001 SHALL have parameter WIDTH, default 30, sprite width in source pixels.
REQ-002 SHALL have parameter HEIGHT, default 45, sprite height in source pixels.
REQ-003 SHALL have parameter FRAMES, default 4, number of animation frames stored back-to-back in the index ROM.
REQ-004 SHALL have parameter SCALE_LOG2, default 0, on-screen magnification 2^SCALE_LOG2 (legal 0..2).
REQ-005 SHALL have parameter FRAME_DIV, default 8, frame_tick pulses per animation step (>=1).
REQ-006 SHALL have parameter TRANSP_IDX, default 8'h00, palette index rendered transparent.
REQ-007 SHALL have parameters IDX_FILE and PAL_FILE, default "", memory init files for index ROM and palette ROM.
REQ-008 pixel_clk  input  1  sole clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high.
REQ-010 x  input  11  sprite left edge, screen pixels.
REQ-011 hcount  input  11  current horizontal scan position.
REQ-012 y  input  10  sprite top edge.
REQ-013 vcount  input  10  current vertical scan position.
REQ-014 frame_tick  input  1  one-cycle pulse, once per video frame (vblank start).
REQ-015 anim_en  input  1  1 = animation advances; 0 = frame held.
REQ-016 loop  input  1  1 = wrap last->first frame; 0 = one-shot, stop on last frame.
REQ-017 restart  input  1  one-cycle pulse, return to frame 0.
REQ-018 pixel  output  24  {R,G,B} 8 bits each.
REQ-019 opaque  output  1  pixel is a sprite-drawn, non-transparent pixel.
REQ-020 frame  output  $clog2(FRAMES) (min 1)  current frame index.
REQ-021 done  output  1  one-shot sequence has reached final frame.

Function
REQ-022 pixel/opaque at edge N+3 SHALL reflect hcount/vcount/x/y sampled at edge N (fixed latency 3: address reg, index ROM, palette ROM); caller offsets hcount by 3.
REQ-023 In-box test SHALL be hcount>=x, hcount<x+(WIDTH<<SCALE_LOG2), vcount>=y, vcount<y+(HEIGHT<<SCALE_LOG2), sums computed 12/11 bits wide so no wrap near screen edge.
REQ-024 Address SHALL be frame*WIDTH*HEIGHT + ((vcount-y)>>SCALE_LOG2)*WIDTH + ((hcount-x)>>SCALE_LOG2), width $clog2(WIDTH*HEIGHT*FRAMES).
REQ-025 Out-of-box or index==TRANSP_IDX SHALL give pixel=0, opaque=0; in-box otherwise pixel=palette[index], opaque=1.
REQ-026 In-box flag SHALL travel in a 3-stage shift register aligned with ROM data.
REQ-027 Tick divider SHALL count frame_tick pulses while anim_en=1; on reaching FRAME_DIV it clears and issues one step.
REQ-028 Step with loop=1: frame increments, FRAMES-1 -> 0.
REQ-029 Step with loop=0: frame increments until FRAMES-1, then holds; done=1 from the cycle frame becomes FRAMES-1 in one-shot mode until restart/reset.
REQ-030 restart SHALL set frame=0, divider=0, done=0 next edge; restart coincident with a step: restart wins.
REQ-031 anim_en=0 SHALL freeze divider and frame; frame_tick ignored.
REQ-032 frame SHALL change only on the edge after frame_tick or restart, never mid-line otherwise.
REQ-033 loop toggled 0->1 while done=1 SHALL clear done and resume wrapping on next step.

Reset
REQ-034 reset SHALL set pixel=0, opaque=0, frame=0, done=0, divider=0, in-box pipeline=0; ROM contents unaffected.
REQ-035 Reset asserted mid-line SHALL force pixel=0/opaque=0 from the next edge until 3 edges after release.

Structure
REQ-036 Shared package SHALL hold RGB width constant (24), screen coordinate widths (11/10) and the transparent-index default.
REQ-037 One sub-module anim_sprite_rom: synchronous-read ROM parameterised DEPTH, DATA_W, INIT_FILE; instantiated twice (index 8-bit, palette 24-bit, 256 deep).

Verification
REQ-038 WIDTH=4,HEIGHT=2,x=100,y=50, hcount 99..104 at vcount=50 -> opaque 0,1,1,1,1,0 three cycles later; pixel matches palette[idx[0..3]].
REQ-039 SCALE_LOG2=1, hcount=101,vcount=51 -> address 0 (same texel as 100,50); hcount=102 -> address 1.
REQ-040 FRAMES=4,FRAME_DIV=2,loop=1,anim_en=1, 10 frame_ticks -> frame 0,0,1,1,2,2,3,3,0,0 sequence wraps; done stays 0.
REQ-041 loop=0, 8 ticks FRAME_DIV=1 -> frame holds at 3, done=1; restart pulse -> frame=0, done=0 next edge; restart and tick same cycle -> frame=0.
REQ-042 Palette index TRANSP_IDX at in-box position -> pixel=0, opaque=0; x=2040 with WIDTH=30 -> no false in-box at hcount=0..9.
REQ-043 reset asserted for 1 cycle mid-sprite at frame 2 -> next edge frame=0, pixel=0, opaque=0.
